// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment table and double-dabble step for seg7_bcd_scan
package seg7_pkg;

  localparam int NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } conv_state_t;

  // Active-high segments, bit0=a .. bit6=g, indexed by decimal digit.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Nibbles above 9 never come out of the converter; map them dark anyway.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    seg_decode = (nib > 4'd9) ? 7'h00 : SEG_TABLE[nib];
  endfunction

  // One double-dabble iteration: correct every nibble >= 5, then shift {bcd, bin} left.
  function automatic logic [19:0] dabble_step(input logic [11:0] bcd, input logic [7:0] bin);
    logic [11:0] adj;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    dabble_step = {adj, bin} << 1;
  endfunction

endpackage

// File: rtl/seg7_bcd_scan_if.sv
// rtl/seg7_bcd_scan_if.sv - load/display bundle between a driver and seg7_bcd_scan
interface seg7_bcd_scan_if;
  logic [7:0] value;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic [2:0] dig_an;

  modport master (output value, output load, input busy, input seg, input dig_an);
  modport slave  (input value, input load, output busy, output seg, output dig_an);
endinterface

// File: rtl/seg7_bcd_scan_bin2bcd_seq.sv
// rtl/seg7_bcd_scan_bin2bcd_seq.sv - sequential 8-bit binary to 3-digit BCD converter (bin2bcd_seq)
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value,
  input  logic        load,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        commit
);

  conv_state_t state, state_nx;
  logic [7:0]  bin;
  logic [2:0]  step;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state and status outputs; loads outside IDLE are simply dropped.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) state_nx = ST_CONVERT;
      end
      ST_CONVERT: begin
        busy = 1'b1;
        if (step == 3'd7) state_nx = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy     = 1'b1;
        commit   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Scratch datapath: capture on accept, one dabble step per CONVERT clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin  <= 8'd0;
      bcd  <= 12'd0;
      step <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            bin  <= value;
            bcd  <= 12'd0;
            step <= 3'd0;
          end
        end
        ST_CONVERT: begin
          {bcd, bin} <= dabble_step(bcd, bin);
          step       <= step + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg7_bcd_scan.sv
// rtl/seg7_bcd_scan.sv - BCD conversion and 3-digit multiplexed 7-seg scan; option SEG7_LEADING_ZERO_BLANK_EN
module seg7_bcd_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_bcd_scan_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    disp [NUM_DIGITS];
  logic [11:0]   bcd;
  logic          commit;
  logic [3:0]    cur;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .value  (bus.value),
    .load   (bus.load),
    .busy   (bus.busy),
    .bcd    (bcd),
    .commit (commit)
  );

  // Prescaler and digit rotation; runs independently of the converter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= 2'd0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Display registers only change on the converter's commit clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= 4'd0;
    end else if (commit) begin
      disp[0] <= bcd[3:0];
      disp[1] <= bcd[7:4];
      disp[2] <= bcd[11:8];
    end
  end

  // Digit select and segment decode from registered state.
  always_comb begin
    bus.dig_an = 3'b001 << idx;
    case (idx)
      2'd1:    cur = disp[1];
      2'd2:    cur = disp[2];
      default: cur = disp[0];
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if ((idx == 2'd2 && disp[2] == 4'd0) ||
        (idx == 2'd1 && disp[2] == 4'd0 && disp[1] == 4'd0))
      bus.seg = 7'h00;
    else
      bus.seg = seg_decode(cur);
`else
    bus.seg = seg_decode(cur);
`endif
  end

endmodule
